// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the keypad operand-entry / arithmetic unit.
//   state_t : entry FSM state, also driven out on estado for observation
//   op_t    : arithmetic operation selected by op_sel at execute time
//   KEY_MAX : largest key code that is a decimal digit
package operand_entry_pkg;

  typedef enum logic [1:0] {
    S_OP1 = 2'd0,  // entering first operand
    S_OP2 = 2'd1,  // entering second operand, first one stored
    S_RES = 2'd2   // result on display
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  localparam logic [3:0] KEY_MAX = 4'd9;

endpackage

// File: rtl/digit_accumulator.sv
// Decimal operand builder: shifts one decimal digit per accepted key into a
// binary value (numero = numero*10 + key) and counts digits entered.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : discard the current operand; when raised together with
//                digit_en the new digit becomes the first digit of a fresh operand
//   digit_en   : one-cycle digit-enter request
//   entrada    : key code (0..9 digit, 10..15 invalid)
//   numero     : operand value in binary
//   full       : DIGITS digits already entered
//   err        : one-cycle pulse when a digit request is rejected
module digit_accumulator
  import operand_entry_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int NW     = $clog2(10**DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          digit_en,
  input  logic [3:0]    entrada,
  output logic [NW-1:0] numero,
  output logic          full,
  output logic          err
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

  logic [CW-1:0] cnt;
  logic [CW-1:0] base_cnt;
  logic [NW-1:0] base;
  logic [NW+3:0] base_ext;
  logic [NW+3:0] scaled;
  logic          accept;

  // The value the new digit is appended to: zero when clearing, so a clear
  // and a digit on the same edge start a new one-digit operand.
  always_comb begin
    base     = clr ? '0 : numero;
    base_cnt = clr ? '0 : cnt;
    base_ext = {4'b0000, base};
    // x*10 as (x<<3)+(x<<1); the digit-count limit keeps the result below 10**DIGITS
    scaled   = (base_ext << 3) + (base_ext << 1) + {{NW{1'b0}}, entrada};
    accept   = digit_en && (entrada <= KEY_MAX) && (base_cnt < CNT_MAX);
  end

  assign full = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      numero <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      err <= digit_en && !accept;
      if (accept) begin
        numero <= scaled[NW-1:0];
        cnt    <= base_cnt + CW'(1);
      end else begin
        numero <= base;
        cnt    <= base_cnt;
      end
    end
  end

endmodule

// File: rtl/operand_entry_adder.sv
// Keypad operand-entry and arithmetic unit. Two decimal operands are typed in
// digit by digit; the first guardar stores operand A, the second computes
// A+B or |A-B| (with sign flag) and shows the result until the next execute.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   push        : digit-enter request (level, acted on at its rising edge)
//   guardar     : store / execute request (level, rising edge)
//   finalizar   : abort / clear request (level, rising edge)
//   entrada     : key code, 0..9 digit
//   op_sel      : 0 add, 1 subtract, sampled on the execute edge
//   numero      : operand being entered
//   numero_sv   : stored first operand
//   resultado   : |A op B|
//   neg         : A-B was negative
//   res_valid   : one-cycle pulse alongside a new resultado/neg
//   err         : one-cycle pulse on a rejected digit
//   estado      : current FSM state
// Request handshake: push/guardar/finalizar are levels; each rise acts exactly
// once at the clock edge where it is first seen, priority finalizar > guardar
// > push, and lower-priority rises on that edge are dropped.
module operand_entry_adder
  import operand_entry_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int NW     = $clog2(10**DIGITS),
  parameter int RW     = NW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          guardar,
  input  logic          finalizar,
  input  logic [3:0]    entrada,
  input  logic          op_sel,
  output logic [NW-1:0] numero,
  output logic [NW-1:0] numero_sv,
  output logic [RW-1:0] resultado,
  output logic          neg,
  output logic          res_valid,
  output logic          err,
  output logic [1:0]    estado
);

  state_t state;
  op_t    op;

  logic push_q, guardar_q, finalizar_q;
  logic fin_act, gua_act, push_act;
  logic acc_clr;

  logic [RW-1:0] a_ext, b_ext, sum, diff;
  logic          a_lt_b;

  // Edge-detect copies. They follow the inputs even while rst is high, so a
  // request that is still held when reset releases is not seen as a new rise.
  always_ff @(posedge clk) begin
    push_q      <= push;
    guardar_q   <= guardar;
    finalizar_q <= finalizar;
  end

  always_comb begin
    fin_act  = finalizar && !finalizar_q;
    gua_act  = guardar && !guardar_q && !fin_act;
    push_act = push && !push_q && !fin_act && !(guardar && !guardar_q);
    // Operand is cleared on abort, when A is stored, and when a new digit
    // starts a fresh calculation after a result.
    acc_clr  = fin_act
             || (gua_act && state == S_OP1)
             || (push_act && state == S_RES);
  end

  digit_accumulator #(
    .DIGITS (DIGITS),
    .NW     (NW)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .digit_en (push_act),
    .entrada  (entrada),
    .numero   (numero),
    .full     (),
    .err      (err)
  );

  assign op = op_t'(op_sel);

  // ALU: A is the stored operand, B the one on entry.
  always_comb begin
    a_ext  = {1'b0, numero_sv};
    b_ext  = {1'b0, numero};
    a_lt_b = (numero_sv < numero);
    sum    = a_ext + b_ext;
    diff   = a_lt_b ? (b_ext - a_ext) : (a_ext - b_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_OP1;
      numero_sv <= '0;
      resultado <= '0;
      neg       <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (fin_act) begin
        // Result is kept on display; only the entry side is cleared.
        state     <= S_OP1;
        numero_sv <= '0;
      end else if (gua_act) begin
        unique case (state)
          S_OP1: begin
            numero_sv <= numero;
            state     <= S_OP2;
          end
          S_OP2: begin
            if (op == OP_SUB) begin
              resultado <= diff;
              neg       <= a_lt_b;
            end else begin
              resultado <= sum;
              neg       <= 1'b0;
            end
            res_valid <= 1'b1;
            state     <= S_RES;
          end
          default: ;  // guardar while showing a result is ignored
        endcase
      end else if (push_act && state == S_RES) begin
        numero_sv <= '0;
        state     <= S_OP1;
      end
    end
  end

  assign estado = state;

endmodule
